binary_mul_acc_4_1: RTL and testbench

Frame accumulator on the output side of the pipelined 4x4 signed multiplier. Consumes the 7-bit signed product stream through a valid/ready handshake and sums one frame of products into a saturating signed accumulator. The frame ends on an in_last-tagged beat or on a beat-count limit. The frame result, beat count and status flags are then presented on a registered valid/ready output to the downstream MAC/result logic.

---
 rtl/binary_mul_pkg.sv | 18 +
 rtl/binary_sat_add.sv | 32 +++
 rtl/binary_mul_acc_4_1.sv | 147 ++++++++++++++
 tb/tb_binary_mul_acc_4_1.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/binary_mul_pkg.sv
// Shared definitions for the binary multiplier datapath: state encoding,
// default widths and the signed accumulator bounds.
package binary_mul_pkg;

    localparam int PROD_W_DEF    = 7;
    localparam int ACC_W_DEF     = 12;
    localparam int MAX_BEATS_DEF = 64;
    localparam int CNT_W         = 7;

    localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = 12'sh7FF;
    localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = 12'sh800;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_e;

endpackage

// File: rtl/binary_sat_add.sv
// Sign-extending adder of a product onto an accumulator, with optional clamp
// to the accumulator range; ovf reports range violation in either mode.
module binary_sat_add
    import binary_mul_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int PROD_W = PROD_W_DEF
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    input  logic              sat_en,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    localparam logic [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] wide_s;

    // One guard bit is enough: the sum of ACC_W and PROD_W signed values fits ACC_W+1 bits.
    always_comb begin
        wide_s = {a[ACC_W-1], a} + {{(ACC_W+1-PROD_W){b[PROD_W-1]}}, b};
        ovf    = wide_s[ACC_W] ^ wide_s[ACC_W-1];
        if (ovf && sat_en) begin
            sum = wide_s[ACC_W] ? SUM_MIN : SUM_MAX;
        end else begin
            sum = wide_s[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/binary_mul_acc_4_1.sv
// Frame accumulator for the 4x4 multiplier product stream: sums one frame of
// products and presents sum, beat count and status on a registered valid/ready port.
module binary_mul_acc_4_1
    import binary_mul_pkg::*;
#(
    parameter int PROD_W    = PROD_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAX_BEATS = MAX_BEATS_DEF,
    parameter bit SAT       = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]  acc_cnt,
    output logic              acc_ovf,
    output logic              acc_len_err
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BEATS);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               out_ovf_q, out_ovf_d;
    logic               out_len_q, out_len_d;

    logic [ACC_W-1:0]   add_sum_s;
    logic               add_ovf_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               accept_s;

    binary_sat_add #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_sat_add (
        .a      (acc_q),
        .b      (in_prod),
        .sat_en (SAT),
        .sum    (add_sum_s),
        .ovf    (add_ovf_s)
    );

    assign in_ready  = (state_q == ACC) & ~clr;
    assign accept_s  = in_valid & in_ready;
    assign cnt_inc_s = cnt_q + 7'd1;

    // Next-state, accumulation and result-capture decode.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        valid_d   = valid_q;
        out_sum_d = out_sum_q;
        out_cnt_d = out_cnt_q;
        out_ovf_d = out_ovf_q;
        out_len_d = out_len_q;
        if (clr) begin
            // Abort discards any partial frame and any unaccepted result.
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (accept_s) begin
                        acc_d = add_sum_s;
                        cnt_d = cnt_inc_s;
                        ovf_d = ovf_q | add_ovf_s;
                        if (in_last || (cnt_inc_s == CNT_LIMIT)) begin
                            out_sum_d = add_sum_s;
                            out_cnt_d = cnt_inc_s;
                            out_ovf_d = ovf_q | add_ovf_s;
                            out_len_d = (cnt_inc_s == CNT_LIMIT) & ~in_last;
                            valid_d   = 1'b1;
                            state_d   = DONE;
                        end else begin
                            state_d = ACC;
                        end
                    end else begin
                        state_d = ACC;
                    end
                end
                DONE: begin
                    if (acc_ready) begin
                        valid_d = 1'b0;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = ACC;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = ACC;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            out_sum_q <= '0;
            out_cnt_q <= '0;
            out_ovf_q <= 1'b0;
            out_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            out_sum_q <= out_sum_d;
            out_cnt_q <= out_cnt_d;
            out_ovf_q <= out_ovf_d;
            out_len_q <= out_len_d;
        end
    end

    assign acc_valid   = valid_q;
    assign acc_out     = out_sum_q;
    assign acc_cnt     = out_cnt_q;
    assign acc_ovf     = out_ovf_q;
    assign acc_len_err = out_len_q;

endmodule

// File: tb/tb_binary_mul_acc_4_1.sv
// Bench for binary_mul_acc_4_1: a clamping and a wrapping instance share one
// stimulus stream; results are compared with a frame-level arithmetic model.
module tb_binary_mul_acc_4_1;

    logic        clk = 1'b0;
    logic        rst_n, clr, in_valid, in_last, acc_ready;
    logic [6:0]  in_prod;

    logic        in_ready_s, acc_valid_s, acc_ovf_s, acc_len_err_s;
    logic [11:0] acc_out_s;
    logic [6:0]  acc_cnt_s;
    logic        in_ready_w, acc_valid_w, acc_ovf_w, acc_len_err_w;
    logic [11:0] acc_out_w;
    logic [6:0]  acc_cnt_w;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int mp[64];
    bit ml[64];

    binary_mul_acc_4_1 #(.SAT(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_prod(in_prod), .in_last(in_last), .acc_valid(acc_valid_s), .acc_ready(acc_ready),
        .acc_out(acc_out_s), .acc_cnt(acc_cnt_s), .acc_ovf(acc_ovf_s), .acc_len_err(acc_len_err_s)
    );

    binary_mul_acc_4_1 #(.SAT(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_prod(in_prod), .in_last(in_last), .acc_valid(acc_valid_w), .acc_ready(acc_ready),
        .acc_out(acc_out_w), .acc_cnt(acc_cnt_w), .acc_ovf(acc_ovf_w), .acc_len_err(acc_len_err_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input int p, input bit l, input int gap);
        int guard;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_prod  = 7'(p);
        in_last  = l;
        guard    = 0;
        #1;
        while (in_ready_s !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            fails++;
            $display("FAIL beat_wait: in_ready=%b required 1 within 200 cycles", in_ready_s);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_frame(input int n, input int gap_max);
        for (int i = 0; i < n; i++) push_beat(mp[i], ml[i], $urandom_range(0, gap_max));
    endtask

    // Frame model from the arithmetic rules: clamp vs modulo-4096 wrap.
    task automatic model_frame(input int n, output int es, output int ew,
                               output bit os, output bit ow, output bit el);
        int s;
        int w;
        es = 0; ew = 0; os = 1'b0; ow = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = es + mp[i];
            if (s > 2047) begin os = 1'b1; s = 2047; end
            else if (s < -2048) begin os = 1'b1; s = -2048; end
            es = s;
            w = ew + mp[i];
            if (w > 2047) begin ow = 1'b1; w -= 4096; end
            else if (w < -2048) begin ow = 1'b1; w += 4096; end
            ew = w;
        end
        el = (n == 64) && !ml[n-1];
    endtask

    task automatic fill_const(input int n, input int v, input bit last_at_end);
        for (int i = 0; i < 64; i++) begin
            mp[i] = v;
            ml[i] = 1'b0;
        end
        if (last_at_end) ml[n-1] = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_prod = 7'd0; acc_ready = 1'b1;
        #3;
        checks++;
        if ({acc_valid_s, acc_out_s, acc_cnt_s, acc_ovf_s, acc_len_err_s} !== 22'd0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b out=%h cnt=%0d ovf=%b len=%b required all 0",
                     acc_valid_s, acc_out_s, acc_cnt_s, acc_ovf_s, acc_len_err_s);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready_s !== 1'b1 || in_ready_w !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b/%b required 1", in_ready_s, in_ready_w);
        end
    endtask

    task automatic test_basic();
        fill_const(3, 0, 1'b1);
        mp[0] = 10; mp[1] = -3; mp[2] = 63;
        acc_ready = 1'b1;
        run_frame(3, 0);
        checks++;
        if (acc_valid_s !== 1'b1 || acc_out_s !== 12'd70 || acc_cnt_s !== 7'd3
            || acc_ovf_s !== 1'b0 || acc_len_err_s !== 1'b0) begin
            fails++;
            $display("FAIL basic_frame: got v=%b out=%0d cnt=%0d ovf=%b len=%b required 1/70/3/0/0",
                     acc_valid_s, $signed(acc_out_s), acc_cnt_s, acc_ovf_s, acc_len_err_s);
        end
        tick();
        checks++;
        if (acc_valid_s !== 1'b0) begin
            fails++;
            $display("FAIL basic_valid_pulse: got acc_valid=%b required 0", acc_valid_s);
        end
    endtask

    task automatic test_saturation();
        int es, ew; bit os, ow, el;
        fill_const(40, 63, 1'b1);
        acc_ready = 1'b0;
        run_frame(40, 0);
        model_frame(40, es, ew, os, ow, el);
        checks++;
        if (acc_valid_s !== 1'b1 || acc_out_s !== 12'(es) || acc_out_s !== 12'd2047
            || acc_ovf_s !== 1'b1 || acc_cnt_s !== 7'd40 || acc_len_err_s !== 1'b0) begin
            fails++;
            $display("FAIL sat_clamp: got out=%0d ovf=%b cnt=%0d required 2047/1/40",
                     $signed(acc_out_s), acc_ovf_s, acc_cnt_s);
        end
        checks++;
        if (acc_valid_w !== 1'b1 || acc_out_w !== 12'(ew) || acc_out_w !== 12'(-1576) || acc_ovf_w !== 1'b1) begin
            fails++;
            $display("FAIL sat_wrap: got out=%0d ovf=%b required -1576/1", $signed(acc_out_w), acc_ovf_w);
        end
        acc_ready = 1'b1;
        tick();
    endtask

    task automatic test_length();
        fill_const(64, -1, 1'b0);
        acc_ready = 1'b1;
        run_frame(64, 0);
        checks++;
        if (acc_valid_s !== 1'b1 || acc_out_s !== 12'(-64) || acc_cnt_s !== 7'd64
            || acc_len_err_s !== 1'b1 || acc_ovf_s !== 1'b0) begin
            fails++;
            $display("FAIL len_limit: got v=%b out=%0d cnt=%0d len=%b required 1/-64/64/1",
                     acc_valid_s, $signed(acc_out_s), acc_cnt_s, acc_len_err_s);
        end
        fill_const(64, -1, 1'b1);
        run_frame(64, 0);
        checks++;
        if (acc_valid_s !== 1'b1 || acc_cnt_s !== 7'd64 || acc_len_err_s !== 1'b0 || acc_len_err_w !== 1'b0) begin
            fails++;
            $display("FAIL len_with_last: got cnt=%0d len=%b required 64/0", acc_cnt_s, acc_len_err_s);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int bad;
        fill_const(2, 0, 1'b1);
        mp[0] = 20; mp[1] = -9;
        acc_ready = 1'b0;
        run_frame(2, 0);
        in_valid = 1'b1; in_prod = 7'd5; in_last = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (in_ready_s !== 1'b0 || acc_valid_s !== 1'b1 || acc_out_s !== 12'd11 || acc_cnt_s !== 7'd2) bad++;
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_hold: got %0d bad cycles (in_ready=%b out=%0d cnt=%0d) required 0 (0/11/2)",
                     bad, in_ready_s, $signed(acc_out_s), acc_cnt_s);
        end
        acc_ready = 1'b1;
        tick();
        checks++;
        if (in_ready_s !== 1'b1 || acc_valid_s !== 1'b0 || acc_out_s !== 12'd11) begin
            fails++;
            $display("FAIL bp_release: got in_ready=%b v=%b out=%0d required 1/0/11",
                     in_ready_s, acc_valid_s, $signed(acc_out_s));
        end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if (acc_valid_s !== 1'b1 || acc_out_s !== 12'd5 || acc_cnt_s !== 7'd1) begin
            fails++;
            $display("FAIL bp_next_frame: got v=%b out=%0d cnt=%0d required 1/5/1",
                     acc_valid_s, $signed(acc_out_s), acc_cnt_s);
        end
        tick();
    endtask

    task automatic test_clr();
        acc_ready = 1'b1;
        push_beat(5, 1'b0, 0);
        push_beat(7, 1'b0, 0);
        in_valid = 1'b1; in_prod = 7'd9; in_last = 1'b0; clr = 1'b1;
        #1;
        checks++;
        if (in_ready_s !== 1'b0) begin
            fails++;
            $display("FAIL clr_in_ready: got %b required 0", in_ready_s);
        end
        tick();
        clr = 1'b0; in_valid = 1'b0;
        tick();
        checks++;
        if (acc_valid_s !== 1'b0) begin
            fails++;
            $display("FAIL clr_no_result: got acc_valid=%b required 0", acc_valid_s);
        end
        fill_const(2, 0, 1'b1);
        mp[0] = 1; mp[1] = 2;
        run_frame(2, 0);
        checks++;
        if (acc_valid_s !== 1'b1 || acc_out_s !== 12'd3 || acc_cnt_s !== 7'd2) begin
            fails++;
            $display("FAIL clr_next_frame: got v=%b out=%0d cnt=%0d required 1/3/2",
                     acc_valid_s, $signed(acc_out_s), acc_cnt_s);
        end
        tick();
        acc_ready = 1'b0;
        push_beat(4, 1'b1, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        checks++;
        if (acc_valid_s !== 1'b0 || in_ready_s !== 1'b1) begin
            fails++;
            $display("FAIL clr_in_done: got v=%b in_ready=%b required 0/1", acc_valid_s, in_ready_s);
        end
        acc_ready = 1'b1;
        push_beat(6, 1'b1, 0);
        checks++;
        if (acc_valid_s !== 1'b1 || acc_out_s !== 12'd6 || acc_cnt_s !== 7'd1) begin
            fails++;
            $display("FAIL clr_done_next: got v=%b out=%0d cnt=%0d required 1/6/1",
                     acc_valid_s, $signed(acc_out_s), acc_cnt_s);
        end
        tick();
    endtask

    task automatic test_async_reset();
        acc_ready = 1'b1;
        push_beat(30, 1'b0, 0);
        push_beat(30, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({acc_valid_s, acc_out_s, acc_cnt_s, acc_ovf_s, acc_len_err_s} !== 22'd0) begin
            fails++;
            $display("FAIL rst_mid_frame: got v=%b out=%h cnt=%0d required all 0", acc_valid_s, acc_out_s, acc_cnt_s);
        end
        #2 rst_n = 1'b1;
        tick();
        acc_ready = 1'b0;
        push_beat(12, 1'b1, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({acc_valid_s, acc_out_s, acc_cnt_s, acc_ovf_s, acc_len_err_s} !== 22'd0) begin
            fails++;
            $display("FAIL rst_in_done: got v=%b out=%h cnt=%0d required all 0", acc_valid_s, acc_out_s, acc_cnt_s);
        end
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready_s !== 1'b1) begin
            fails++;
            $display("FAIL rst_release_ready: got %b required 1", in_ready_s);
        end
        acc_ready = 1'b1;
        push_beat(-5, 1'b1, 0);
        checks++;
        if (acc_valid_s !== 1'b1 || acc_out_s !== 12'(-5) || acc_cnt_s !== 7'd1) begin
            fails++;
            $display("FAIL rst_next_frame: got v=%b out=%0d cnt=%0d required 1/-5/1",
                     acc_valid_s, $signed(acc_out_s), acc_cnt_s);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int start;
        acc_ready = 1'b1;
        start = cyc;
        fill_const(4, 3, 1'b1);
        run_frame(4, 0);
        checks++;
        if (acc_valid_s !== 1'b1 || acc_out_s !== 12'd12 || (cyc - start) != 4) begin
            fails++;
            $display("FAIL b2b_first: got v=%b out=%0d cycles=%0d required 1/12/4",
                     acc_valid_s, $signed(acc_out_s), cyc - start);
        end
        fill_const(3, -2, 1'b1);
        run_frame(3, 0);
        checks++;
        if (acc_valid_s !== 1'b1 || acc_out_s !== 12'(-6) || (cyc - start) != 8) begin
            fails++;
            $display("FAIL b2b_second: got v=%b out=%0d cycles=%0d required 1/-6/8",
                     acc_valid_s, $signed(acc_out_s), cyc - start);
        end
        tick();
    endtask

    task automatic test_random();
        int n, es, ew, hold;
        bit os, ow, el;
        logic signed [6:0] r;
        for (int f = 0; f < 30; f++) begin
            n = ($urandom_range(0, 7) == 0) ? 64 : $urandom_range(1, 12);
            for (int i = 0; i < 64; i++) begin
                r = 7'($urandom);
                mp[i] = (f % 2 == 1) ? $urandom_range(40, 63) : int'(r);
                ml[i] = 1'b0;
            end
            if (n < 64 || $urandom_range(0, 1) == 1) ml[n-1] = 1'b1;
            acc_ready = 1'b0;
            run_frame(n, 2);
            model_frame(n, es, ew, os, ow, el);
            hold = $urandom_range(0, 3);
            repeat (hold) tick();
            checks++;
            if (acc_valid_s !== 1'b1 || acc_out_s !== 12'(es) || acc_cnt_s !== 7'(n)
                || acc_ovf_s !== os || acc_len_err_s !== el) begin
                fails++;
                $display("FAIL rand_sat f=%0d: got v=%b out=%0d cnt=%0d ovf=%b len=%b required 1/%0d/%0d/%b/%b",
                         f, acc_valid_s, $signed(acc_out_s), acc_cnt_s, acc_ovf_s, acc_len_err_s, es, n, os, el);
            end
            checks++;
            if (acc_valid_w !== 1'b1 || acc_out_w !== 12'(ew) || acc_cnt_w !== 7'(n) || acc_ovf_w !== ow) begin
                fails++;
                $display("FAIL rand_wrap f=%0d: got out=%0d cnt=%0d ovf=%b required %0d/%0d/%b",
                         f, $signed(acc_out_w), acc_cnt_w, acc_ovf_w, ew, n, ow);
            end
            acc_ready = 1'b1;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_length();
        test_backpressure();
        test_clr();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
